fault_inject_memory: RTL and testbench

Behavioural single-port memory responder with run-time fault injection, used as the target on the memory side of the MBIST/MBISR path. It answers the same mem_en/mem_we/mem_addr/mem_wdata/mem_rdata transactions the MBISR controller issues. It can be programmed with up to NUM_FAULTS single-bit cell faults (stuck-at-0, stuck-at-1, rising-transition), so the BIST and repair flow can be exercised against known defects. After reset it sweeps the array to zero before accepting traffic.

---
 rtl/fault_inject_memory.sv | 186 ++++++++++++++++++
 tb/tb_fault_inject_memory.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fault_inject_memory.sv
// Single-port memory responder with run-time programmable single-bit cell faults.
// After reset it clears every word, then serves 1-cycle-latency reads and writes.
// Faults are applied when a word is written, and stuck-at faults are applied again when it is read.
module fault_inject_memory #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MEM_SIZE   = 256,
  parameter int unsigned NUM_FAULTS = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          mem_en,
  input  logic                          mem_we,
  input  logic [ADDR_WIDTH-1:0]         mem_addr,
  input  logic [DATA_WIDTH-1:0]         mem_wdata,
  output logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          init_done,
  input  logic                          fault_cfg_we,
  input  logic [$clog2(NUM_FAULTS)-1:0] fault_cfg_idx,
  input  logic [ADDR_WIDTH-1:0]         fault_cfg_addr,
  input  logic [$clog2(DATA_WIDTH)-1:0] fault_cfg_bit,
  input  logic [1:0]                    fault_cfg_type,
  output logic [7:0]                    fault_hits
);

  localparam int unsigned BitW = $clog2(DATA_WIDTH);

  localparam logic [0:0] StInit  = 1'b0;
  localparam logic [0:0] StReady = 1'b1;

  localparam logic [1:0] FtNone = 2'b00;
  localparam logic [1:0] FtSa0  = 2'b01;
  localparam logic [1:0] FtSa1  = 2'b10;
  localparam logic [1:0] FtTfUp = 2'b11;

  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(MEM_SIZE - 1);

  // Storage and state
  logic [DATA_WIDTH-1:0] mem_q [MEM_SIZE];

  logic [0:0]            state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  done_q, done_d;
  logic [7:0]            hits_q, hits_d;

  logic [1:0]            slot_type_q [NUM_FAULTS];
  logic [ADDR_WIDTH-1:0] slot_addr_q [NUM_FAULTS];
  logic [BitW-1:0]       slot_bit_q  [NUM_FAULTS];

  // Memory write port, driven either by the clear sweep or by user writes
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  // Access decode
  logic                  in_range;
  logic                  acc_rd;
  logic                  acc_wr;
  logic [DATA_WIDTH-1:0] stored;
  logic [DATA_WIDTH-1:0] wdata_faulted;
  logic [DATA_WIDTH-1:0] rdata_faulted;
  logic                  slot_hit;

  assign in_range = (32'(mem_addr) < MEM_SIZE);
  assign acc_rd   = (state_q == StReady) && mem_en && !mem_we;
  assign acc_wr   = (state_q == StReady) && mem_en && mem_we;
  assign stored   = in_range ? mem_q[mem_addr] : '0;

  // Apply the enabled slots that match the address, in ascending index order (the highest index wins)
  always_comb begin
    wdata_faulted = mem_wdata;
    rdata_faulted = stored;
    slot_hit      = 1'b0;
    for (int i = 0; i < int'(NUM_FAULTS); i++) begin
      if (slot_type_q[i] != FtNone && slot_addr_q[i] == mem_addr) begin
        slot_hit = 1'b1;
        unique case (slot_type_q[i])
          FtSa0: begin
            wdata_faulted[slot_bit_q[i]] = 1'b0;
            rdata_faulted[slot_bit_q[i]] = 1'b0;
          end
          FtSa1: begin
            wdata_faulted[slot_bit_q[i]] = 1'b1;
            rdata_faulted[slot_bit_q[i]] = 1'b1;
          end
          FtTfUp: begin
            // Cell cannot rise: a 0->1 write leaves the stored 0 in place
            if (!stored[slot_bit_q[i]] && wdata_faulted[slot_bit_q[i]]) begin
              wdata_faulted[slot_bit_q[i]] = 1'b0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Select the write-port source: the sweep during INIT, user traffic in READY
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = mem_addr;
    wr_data = wdata_faulted;
    if (!rst) begin
      if (state_q == StInit) begin
        wr_en   = 1'b1;
        wr_addr = ptr_q;
        wr_data = '0;
      end else if (acc_wr && in_range) begin
        wr_en = 1'b1;
      end
    end
  end

  // Next-state logic for the sweep FSM, read data and hit counter
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rdata_d = rdata_q;
    done_d  = done_q;
    hits_d  = hits_q;
    unique case (state_q)
      StInit: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LastAddr) begin
          state_d = StReady;
          done_d  = 1'b1;
          ptr_d   = '0;
        end
      end
      StReady: begin
        if (acc_rd) begin
          rdata_d = in_range ? rdata_faulted : '0;
          if (in_range && slot_hit && hits_q != 8'hFF) begin
            hits_d = hits_q + 8'd1;
          end
        end
      end
      default: state_d = StInit;
    endcase
  end

  // Control registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StInit;
      ptr_q   <= '0;
      rdata_q <= '0;
      done_q  <= 1'b0;
      hits_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rdata_q <= rdata_d;
      done_q  <= done_d;
      hits_q  <= hits_d;
    end
  end

  // Fault slot table: can be written in any state and is cleared by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NUM_FAULTS); i++) begin
        slot_type_q[i] <= FtNone;
        slot_addr_q[i] <= '0;
        slot_bit_q[i]  <= '0;
      end
    end else if (fault_cfg_we) begin
      slot_type_q[fault_cfg_idx] <= fault_cfg_type;
      slot_addr_q[fault_cfg_idx] <= fault_cfg_addr;
      slot_bit_q[fault_cfg_idx]  <= fault_cfg_bit;
    end
  end

  // Memory array has no reset; the post-reset sweep clears it
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign mem_rdata  = rdata_q;
  assign init_done  = done_q;
  assign fault_hits = hits_q;

endmodule

// File: tb/tb_fault_inject_memory.sv
// Directed self-checking bench for fault_inject_memory.
module tb_fault_inject_memory;

  logic       clk = 1'b0;
  logic       rst;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       init_done;
  logic       fault_cfg_we;
  logic [1:0] fault_cfg_idx;
  logic [7:0] fault_cfg_addr;
  logic [2:0] fault_cfg_bit;
  logic [1:0] fault_cfg_type;
  logic [7:0] fault_hits;

  int checks   = 0;
  int failures = 0;

  fault_inject_memory #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .MEM_SIZE  (256),
    .NUM_FAULTS(4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .mem_en        (mem_en),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .init_done     (init_done),
    .fault_cfg_we  (fault_cfg_we),
    .fault_cfg_idx (fault_cfg_idx),
    .fault_cfg_addr(fault_cfg_addr),
    .fault_cfg_bit (fault_cfg_bit),
    .fault_cfg_type(fault_cfg_type),
    .fault_hits    (fault_hits)
  );

  always #5 clk = ~clk;

  // Advance one clock edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    fault_cfg_we = 1'b0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d);
    mem_en = 1'b1; mem_we = 1'b1; mem_addr = a; mem_wdata = d;
    tick();
    idle();
  endtask

  task automatic do_read(input logic [7:0] a);
    mem_en = 1'b1; mem_we = 1'b0; mem_addr = a;
    tick();
    idle();
  endtask

  task automatic do_cfg(input logic [1:0] idx, input logic [7:0] a, input logic [2:0] b,
                        input logic [1:0] t);
    fault_cfg_we = 1'b1; fault_cfg_idx = idx; fault_cfg_addr = a;
    fault_cfg_bit = b; fault_cfg_type = t;
    tick();
    idle();
  endtask

  // Bounded wait for init_done; returns the number of edges taken
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (!init_done && cnt < 400) begin
      tick();
      cnt++;
    end
  endtask

  task automatic test_reset();
    int cnt;
    int bad;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (init_done !== 1'b0) begin
      failures++; $display("FAIL reset_init_done got=%b exp=0", init_done);
    end
    checks++;
    if (mem_rdata !== 8'h00) begin
      failures++; $display("FAIL reset_rdata got=%h exp=00", mem_rdata);
    end
    checks++;
    if (fault_hits !== 8'h00) begin
      failures++; $display("FAIL reset_hits got=%0d exp=0", fault_hits);
    end
    wait_done(cnt);
    checks++;
    if (cnt !== 256) begin
      failures++; $display("FAIL sweep_length got=%0d exp=256", cnt);
    end
    bad = 0;
    for (int a = 0; a < 256; a++) begin
      do_read(8'(a));
      if (mem_rdata !== 8'h00) bad++;
    end
    checks++;
    if (bad !== 0) begin
      failures++; $display("FAIL cleared_array nonzero_words got=%0d exp=0", bad);
    end
    checks++;
    if (fault_hits !== 8'h00) begin
      failures++; $display("FAIL sweep_hits got=%0d exp=0", fault_hits);
    end
  endtask

  task automatic test_basic();
    do_write(8'h10, 8'hA5);
    checks++;
    if (mem_rdata !== 8'h00) begin
      failures++; $display("FAIL write_keeps_rdata got=%h exp=00", mem_rdata);
    end
    do_read(8'h10);
    checks++;
    if (mem_rdata !== 8'hA5) begin
      failures++; $display("FAIL basic_read got=%h exp=a5", mem_rdata);
    end
    tick(); tick(); tick();
    checks++;
    if (mem_rdata !== 8'hA5) begin
      failures++; $display("FAIL rdata_hold got=%h exp=a5", mem_rdata);
    end
  endtask

  task automatic test_sa1();
    do_cfg(2'd0, 8'h20, 3'd3, 2'b10);
    do_read(8'h20);
    checks++;
    if (mem_rdata !== 8'h08) begin
      failures++; $display("FAIL sa1_read_unwritten got=%h exp=08", mem_rdata);
    end
    do_write(8'h20, 8'h00);
    do_read(8'h20);
    checks++;
    if (mem_rdata !== 8'h08) begin
      failures++; $display("FAIL sa1_read_after_write got=%h exp=08", mem_rdata);
    end
    checks++;
    if (fault_hits !== 8'd2) begin
      failures++; $display("FAIL sa1_hits got=%0d exp=2", fault_hits);
    end
  endtask

  task automatic test_tf();
    do_cfg(2'd1, 8'h30, 3'd0, 2'b11);
    do_write(8'h30, 8'h00);
    do_write(8'h30, 8'hFF);
    do_read(8'h30);
    checks++;
    if (mem_rdata !== 8'hFE) begin
      failures++; $display("FAIL tf_rise_blocked got=%h exp=fe", mem_rdata);
    end
    do_write(8'h30, 8'h00);
    do_read(8'h30);
    checks++;
    if (mem_rdata !== 8'h00) begin
      failures++; $display("FAIL tf_fall_passes got=%h exp=00", mem_rdata);
    end
    checks++;
    if (fault_hits !== 8'd4) begin
      failures++; $display("FAIL tf_hits got=%0d exp=4", fault_hits);
    end
  endtask

  task automatic test_priority();
    do_cfg(2'd2, 8'h40, 3'd7, 2'b01);
    do_cfg(2'd3, 8'h40, 3'd7, 2'b10);
    do_write(8'h40, 8'h00);
    do_read(8'h40);
    checks++;
    if (mem_rdata !== 8'h80) begin
      failures++; $display("FAIL slot3_wins got=%h exp=80", mem_rdata);
    end
    // Disable slot3 in the same cycle as a read: the old slot still applies
    fault_cfg_we = 1'b1; fault_cfg_idx = 2'd3; fault_cfg_addr = 8'h40;
    fault_cfg_bit = 3'd7; fault_cfg_type = 2'b00;
    mem_en = 1'b1; mem_we = 1'b0; mem_addr = 8'h40;
    tick();
    idle();
    checks++;
    if (mem_rdata !== 8'h80) begin
      failures++; $display("FAIL cfg_same_cycle got=%h exp=80", mem_rdata);
    end
    do_read(8'h40);
    checks++;
    if (mem_rdata !== 8'h00) begin
      failures++; $display("FAIL cfg_next_cycle got=%h exp=00", mem_rdata);
    end
    checks++;
    if (fault_hits !== 8'd7) begin
      failures++; $display("FAIL priority_hits got=%0d exp=7", fault_hits);
    end
  endtask

  task automatic test_saturate();
    mem_en = 1'b1; mem_we = 1'b0; mem_addr = 8'h20;
    for (int i = 0; i < 300; i++) tick();
    idle();
    checks++;
    if (fault_hits !== 8'd255) begin
      failures++; $display("FAIL hits_saturate got=%0d exp=255", fault_hits);
    end
    do_read(8'h10);
    checks++;
    if (fault_hits !== 8'd255 || mem_rdata !== 8'hA5) begin
      failures++;
      $display("FAIL unfaulted_read got hits=%0d data=%h exp hits=255 data=a5",
               fault_hits, mem_rdata);
    end
  endtask

  task automatic test_midsweep_reset();
    int cnt;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 100; i++) tick();
    checks++;
    if (init_done !== 1'b0) begin
      failures++; $display("FAIL midsweep_done got=%b exp=0", init_done);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (fault_hits !== 8'd0) begin
      failures++; $display("FAIL midsweep_hits_clear got=%0d exp=0", fault_hits);
    end
    wait_done(cnt);
    checks++;
    if (cnt !== 256) begin
      failures++; $display("FAIL resweep_length got=%0d exp=256", cnt);
    end
    do_read(8'h20);
    checks++;
    if (mem_rdata !== 8'h00 || fault_hits !== 8'd0) begin
      failures++;
      $display("FAIL slots_cleared got data=%h hits=%0d exp data=00 hits=0",
               mem_rdata, fault_hits);
    end
    do_read(8'h10);
    checks++;
    if (mem_rdata !== 8'h00) begin
      failures++; $display("FAIL array_recleared got=%h exp=00", mem_rdata);
    end
  endtask

  initial begin
    rst = 1'b1;
    mem_addr = '0; mem_wdata = '0;
    fault_cfg_idx = '0; fault_cfg_addr = '0; fault_cfg_bit = '0; fault_cfg_type = '0;
    idle();
    tick();
    test_reset();
    test_basic();
    test_sa1();
    test_tf();
    test_priority();
    test_saturate();
    test_midsweep_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
